// File: rtl/lfsr_period_meter.sv
// Period monitor for the 8-bit LFSR stage: captures the seed after each load,
// counts shift cycles until it reappears and flags lock-up, runaway and inconsistent periods.
module lfsr_period_meter #(
    parameter int MAX_COUNT = 511
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sel,
    input  logic [1:8] Y,
    output logic [8:0] period,
    output logic       period_valid,
    output logic       locked,
    output logic       mismatch,
    output logic       stuck,
    output logic       timeout
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARM     = 3'd1;
    localparam logic [2:0] MEASURE = 3'd2;
    localparam logic [2:0] LOCKED  = 3'd3;
    localparam logic [2:0] FAULT   = 3'd4;

    localparam logic [8:0] COUNT_MAX = 9'(MAX_COUNT);

    logic [2:0] state_r,  state_s;
    logic [1:8] ref_r,    ref_s;
    logic [8:0] count_r,  count_s;
    logic [8:0] first_r,  first_s;
    logic [8:0] period_r, period_s;
    logic       period_valid_r, period_valid_s;
    logic       locked_r,   locked_s;
    logic       mismatch_r, mismatch_s;
    logic       stuck_r,    stuck_s;
    logic       timeout_r,  timeout_s;
    logic       match_s;

    assign match_s = (Y == ref_r);

    // Next-state and output computation; a load strobe overrides every state.
    always_comb begin
        state_s        = state_r;
        ref_s          = ref_r;
        count_s        = count_r;
        first_s        = first_r;
        period_s       = period_r;
        period_valid_s = 1'b0;
        locked_s       = locked_r;
        mismatch_s     = mismatch_r;
        stuck_s        = stuck_r;
        timeout_s      = timeout_r;
        if (sel) begin
            state_s    = ARM;
            count_s    = 9'd0;
            locked_s   = 1'b0;
            mismatch_s = 1'b0;
            stuck_s    = 1'b0;
            timeout_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                ARM: begin
                    ref_s   = Y;
                    count_s = 9'd1;
                    if (Y == 8'h00) begin
                        stuck_s = 1'b1;
                        state_s = FAULT;
                    end else begin
                        state_s = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    // A match on the saturating count still wins over the timeout.
                    if (match_s) begin
                        period_s       = count_r;
                        period_valid_s = 1'b1;
                        locked_s       = 1'b1;
                        count_s        = 9'd1;
                        state_s        = LOCKED;
                        if (state_r == MEASURE) begin
                            first_s = count_r;
                        end else if (count_r != first_r) begin
                            mismatch_s = 1'b1;
                        end else begin
                            mismatch_s = mismatch_r;
                        end
                    end else if (count_r == COUNT_MAX) begin
                        timeout_s = 1'b1;
                        state_s   = FAULT;
                    end else begin
                        count_s = count_r + 9'd1;
                    end
                end
                FAULT: begin
                    state_s = FAULT;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            ref_r          <= 8'h00;
            count_r        <= 9'd0;
            first_r        <= 9'd0;
            period_r       <= 9'd0;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            mismatch_r     <= 1'b0;
            stuck_r        <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            ref_r          <= ref_s;
            count_r        <= count_s;
            first_r        <= first_s;
            period_r       <= period_s;
            period_valid_r <= period_valid_s;
            locked_r       <= locked_s;
            mismatch_r     <= mismatch_s;
            stuck_r        <= stuck_s;
            timeout_r      <= timeout_s;
        end
    end

    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign mismatch     = mismatch_r;
    assign stuck        = stuck_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// Scoreboard bench for lfsr_period_meter: expected periods are queued as the
// seed is driven back onto Y and compared when period_valid pulses.
module tb_lfsr_period_meter;

    logic       clock;
    logic       reset_n;
    logic       sel;
    logic [1:8] y_in;
    logic [8:0] period;
    logic       period_valid;
    logic       locked;
    logic       mismatch;
    logic       stuck;
    logic       timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_p;

    lfsr_period_meter #(.MAX_COUNT(511)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sel          (sel),
        .Y            (y_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .mismatch     (mismatch),
        .stuck        (stuck),
        .timeout      (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one edge; exp_period != 0 means that edge returns Y to the seed.
    task automatic tick(input logic s, input logic [7:0] y, input int exp_period);
        sel  = s;
        y_in = y;
        @(posedge clock);
        if (exp_period != 0) exp_q.push_back(9'(exp_period));
        #1;
    endtask

    // One full period of length p after the seed: p-1 distinct non-seed values, then the seed.
    task automatic period_run(input logic [7:0] seed, input int p);
        for (int i = 0; i < p - 1; i++) tick(1'b0, seed ^ 8'(i % 255 + 1), 0);
        tick(1'b0, seed, p);
    endtask

    // Pulse timing and period value are checked one half-cycle after each edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0 || period_valid) begin
            check("period_valid", 32'(period_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                exp_p = exp_q.pop_front();
                if (period_valid) check("period", 32'(period), 32'(exp_p));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        sel     = 1'b0;
        y_in    = 8'h00;
        tick(1'b0, 8'h00, 0);
        tick(1'b0, 8'h00, 0);
        reset_n = 1'b1;
        tick(1'b0, 8'h00, 0);
        check("rst_period",   32'(period),       32'd0);
        check("rst_pv",       32'(period_valid), 32'd0);
        check("rst_locked",   32'(locked),       32'd0);
        check("rst_mismatch", 32'(mismatch),     32'd0);
        check("rst_stuck",    32'(stuck),        32'd0);
        check("rst_timeout",  32'(timeout),      32'd0);

        // Seed D3, sel high two cycles, three periods of 5.
        tick(1'b1, 8'hD3, 0);
        tick(1'b1, 8'hD3, 0);
        tick(1'b0, 8'hD3, 0);
        check("arm_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 3; k++) period_run(8'hD3, 5);
        check("p5_period",   32'(period),   32'd5);
        check("p5_locked",   32'(locked),   32'd1);
        check("p5_mismatch", 32'(mismatch), 32'd0);

        // Seed B3, period 255 twice.
        tick(1'b1, 8'hB3, 0);
        check("load_clears_locked", 32'(locked), 32'd0);
        check("load_keeps_period",  32'(period), 32'd5);
        tick(1'b0, 8'hB3, 0);
        period_run(8'hB3, 255);
        period_run(8'hB3, 255);
        check("p255_period",  32'(period),  32'd255);
        check("p255_locked",  32'(locked),  32'd1);
        check("p255_timeout", 32'(timeout), 32'd0);

        // All-zero seed locks up; Y held at zero must not produce a match.
        tick(1'b1, 8'h00, 0);
        tick(1'b0, 8'h00, 0);
        check("stuck_set",     32'(stuck),  32'd1);
        check("stuck_locked",  32'(locked), 32'd0);
        check("stuck_period",  32'(period), 32'd255);
        for (int k = 0; k < 4; k++) tick(1'b0, 8'h00, 0);
        check("stuck_hold", 32'(stuck), 32'd1);

        // Fixed-point seed: period 1 with a pulse every cycle.
        tick(1'b1, 8'h5A, 0);
        check("stuck_clear", 32'(stuck), 32'd0);
        tick(1'b0, 8'h5A, 0);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h5A, 1);
        check("p1_period", 32'(period), 32'd1);

        // Seed D3 never returns: timeout after 511 counting edges.
        tick(1'b1, 8'hD3, 0);
        tick(1'b0, 8'hD3, 0);
        for (int i = 0; i < 510; i++) tick(1'b0, 8'hD3 ^ 8'(i % 255 + 1), 0);
        check("timeout_early", 32'(timeout), 32'd0);
        tick(1'b0, 8'h11, 0);
        check("timeout_set", 32'(timeout), 32'd1);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'hD3, 0);
        check("timeout_hold", 32'(timeout), 32'd1);
        tick(1'b1, 8'hB3, 0);
        check("timeout_clear", 32'(timeout), 32'd0);
        tick(1'b0, 8'hB3, 0);
        period_run(8'hB3, 3);
        check("p3_period", 32'(period), 32'd3);

        // Seed returns exactly when the count saturates: match wins.
        tick(1'b1, 8'h3C, 0);
        tick(1'b0, 8'h3C, 0);
        period_run(8'h3C, 511);
        check("p511_period",  32'(period),  32'd511);
        check("p511_timeout", 32'(timeout), 32'd0);
        check("p511_locked",  32'(locked),  32'd1);

        // Periods 5 then 6 raise mismatch; a load (even on a match edge) clears it.
        tick(1'b1, 8'hD3, 0);
        tick(1'b0, 8'hD3, 0);
        period_run(8'hD3, 5);
        check("mm_after5", 32'(mismatch), 32'd0);
        period_run(8'hD3, 6);
        check("mm_set",    32'(mismatch), 32'd1);
        check("mm_period", 32'(period),   32'd6);
        tick(1'b1, 8'hD3, 0);
        check("mm_clear",        32'(mismatch), 32'd0);
        check("mm_load_period",  32'(period),   32'd6);

        // Asynchronous reset mid-measurement, between edges.
        tick(1'b0, 8'hD3, 0);
        tick(1'b0, 8'h44, 0);
        tick(1'b0, 8'h45, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_period",   32'(period),   32'd0);
        check("arst_locked",   32'(locked),   32'd0);
        check("arst_mismatch", 32'(mismatch), 32'd0);
        #2 reset_n = 1'b1;
        tick(1'b0, 8'hD3, 0);
        tick(1'b0, 8'h00, 0);
        tick(1'b0, 8'hD3, 0);
        check("idle_stuck",  32'(stuck),  32'd0);
        check("idle_period", 32'(period), 32'd0);
        tick(1'b1, 8'h77, 0);
        tick(1'b0, 8'h77, 0);
        period_run(8'h77, 4);
        check("post_rst_period", 32'(period), 32'd4);

        tick(1'b0, 8'h12, 0);
        tick(1'b0, 8'h13, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_period_meter.md
# lfsr_period_meter

Downstream monitor for the 8-bit LFSR stage. It watches the LFSR output `Y[1:8]` and the same `sel` load strobe that drives the LFSR. After each load it captures the seed and counts shift cycles until the seed reappears, then reports the sequence period. It also flags all-zero lock-up, runaway sequences and period inconsistency, so the lab bench can verify maximal-length tap choices without reading waveforms.

## Interface
- `MAX_COUNT`, default 511: saturation and timeout limit for the cycle counter. Must fit in 9 bits.
- `clock` in 1: rising-edge clock, shared with the LFSR.
- `reset_n` in 1: asynchronous, active-low reset.
- `sel` in 1: LFSR load strobe, same net as the LFSR `sel`. 1 = LFSR loads `initial_state` at this edge.
- `Y` in [1:8]: LFSR state, sampled at every rising edge.
- `period` out [8:0]: last measured period in clock cycles. Reset value 0.
- `period_valid` out 1: one-cycle pulse when `period` updates. Reset value 0.
- `locked` out 1: at least one period has been measured since the last load. Reset value 0.
- `mismatch` out 1: sticky. A later period differed from the first. Reset value 0.
- `stuck` out 1: sticky. The seed captured after a load was 8'h00. Reset value 0.
- `timeout` out 1: sticky. No return to the seed within `MAX_COUNT` cycles. Reset value 0.

## Operation
- Registered state: FSM state (IDLE, ARM, MEASURE, LOCKED, FAULT), `ref[1:8]`, `count[8:0]`, `first[8:0]` and all outputs.
- `sel`=1 at any edge, in any state:
  - next state is ARM;
  - `locked`, `mismatch`, `stuck` and `timeout` clear;
  - `count` clears to 0;
  - `period` keeps its value.
- IDLE: entered at reset. Waits for `sel`=1.
- ARM, at the first edge with `sel`=0: `Y` now holds the loaded seed.
  - `ref` <= `Y` and `count` <= 1.
  - If `Y`==8'h00: `stuck` <= 1 and go to FAULT.
  - Otherwise go to MEASURE.
- MEASURE, at each edge with `sel`=0:
  - If `Y`==`ref`: `period` <= `count`, `first` <= `count`, pulse `period_valid`, `locked` <= 1, `count` <= 1, go to LOCKED.
  - Else if `count`==`MAX_COUNT`: `timeout` <= 1 and go to FAULT.
  - Else `count` <= `count`+1.
- LOCKED: measures continuously with the same match rules as MEASURE.
  - On each match, `period` updates and `period_valid` pulses.
  - If the new count differs from `first`, `mismatch` <= 1. It stays set until the next load.
  - Timeout in LOCKED also sets `timeout` and moves to FAULT.
- FAULT: holds all outputs and does not count. Leaves only on `sel`=1.
- `count` never wraps. It saturates at `MAX_COUNT`, and that saturation is the timeout.
- Reset asserted mid-measurement aborts immediately. All outputs go to their reset values and the state goes to IDLE.

## Timing
- All outputs are registered and change only on the rising edge of `clock`. The exception is the asynchronous clear from `reset_n`.
- Capture edge: the first edge after the load edge at which `sel`=0. If `sel` is held high for N cycles, capture happens at the first low edge.
- Period latency: with capture at edge k, a return to the seed visible on `Y` at edge k+P gives `period`=P and `period_valid`=1 during the cycle after edge k+P.
- `period_valid` is never high for two consecutive cycles unless P=1.
- A seed that is a fixed point gives `period`=1, with a `period_valid` pulse every cycle.
- Simultaneous match and `sel`=1 at the same edge: the load wins. No `period_valid` pulse.
- Simultaneous match and `count`==`MAX_COUNT`: the match wins. No timeout.
- `sel` going high one cycle after reset release is accepted normally.

## Test plan
- Load seed 8'hD3 (`sel` high 2 cycles), then the bench drives `Y` through a 5-state cycle that returns to D3 -> `period`=5 with a `period_valid` pulse 5 edges after capture; `locked`=1; `mismatch`=0 after three periods.
- Load 8'hB3, then a repeating cycle of length 255 -> `period`=255, `locked`=1, no `timeout`.
- Load 8'h00 -> `stuck`=1 one edge after `sel` falls; state FAULT; `period` keeps its previous value.
- Load 8'hD3, then the bench never returns `Y` to D3 -> `timeout`=1 after 511 counting edges; then reload 8'hB3 -> `timeout` clears at the load edge.
- Load 8'hD3, with periods of 5 then 6 -> `mismatch`=1 after the second pulse and `period`=6; reassert `sel` -> `mismatch`=0.
- Assert `reset_n`=0 mid-MEASURE, asynchronously and between edges -> all outputs read 0 before the next edge; after release, no activity until `sel`=1.
